// File: rtl/lcd_spi_frame_master.sv
// rtl/lcd_spi_frame_master.sv - SPI frame master for the LCD panel with D/C, CS hold and runtime divider
module lcd_spi_frame_master #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              len8,
    input  logic              dc_in,
    input  logic              keep_cs,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic              cs_n,
    output logic              dc,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, TAIL} state_t;

    state_t            state_q, state_d;
    logic [DIV_W:0]    cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              len8_q, len8_d;
    logic              keep_q, keep_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              dc_q, dc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              tick;
    logic              leading;
    logic              last_hit;
    logic [EW-1:0]     last_edge;

    // One SCK half-period elapsed; edge parity picks leading/trailing; last edge depends on frame length
    assign tick      = (cnt_q == {1'b0, div_q});
    assign leading   = ~edge_q[0];
    assign last_edge = len8_q ? EW'(15) : EW'(2 * DATA_W - 1);
    assign last_hit  = (edge_q == last_edge);

    // Next-state logic: accept, setup delay, 2N SCK edges, then tail before done
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        div_d      = div_q;
        len8_d     = len8_q;
        keep_d     = keep_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        dc_d       = dc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // 8-bit frames are left-aligned so the shifter always transmits from the top bit
                    tx_d    = len8 ? (data_in << (DATA_W - 8)) : data_in;
                    if (!CPHA) begin
                        mosi_d = tx_d[DATA_W-1];
                    end
                    rx_d    = '0;
                    cnt_d   = '0;
                    edge_d  = '0;
                    div_d   = clk_div;
                    len8_d  = len8;
                    keep_d  = keep_cs;
                    dc_d    = dc_in;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP, XFER: begin
                if (tick) begin
                    cnt_d   = '0;
                    edge_d  = edge_q + 1'b1;
                    state_d = last_hit ? TAIL : XFER;
                    sck_d   = leading ? ~CPOL : CPOL;
                    if (leading ^ CPHA) begin
                        rx_d = {rx_q[DATA_W-2:0], miso};
                    end else if (CPHA) begin
                        mosi_d = tx_q[DATA_W-1];
                        tx_d   = tx_q << 1;
                    end else if (!last_hit) begin
                        mosi_d = tx_q[DATA_W-2];
                        tx_d   = tx_q << 1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TAIL: begin
                cnt_d = cnt_q + 1'b1;
                // Tail spans 2D-1 cycles after the last edge so done lands (2N+2)*D after accept
                if (cnt_q == {div_q, 1'b0}) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    data_out_d = rx_q;
                    cs_n_d     = ~keep_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any frame immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            div_q      <= '0;
            len8_q     <= 1'b0;
            keep_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            sck_q      <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            dc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            div_q      <= div_d;
            len8_q     <= len8_d;
            keep_q     <= keep_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            dc_q       <= dc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign dc       = dc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_lcd_spi_frame_master.sv
// tb/tb_lcd_spi_frame_master.sv - scoreboard bench for lcd_spi_frame_master (mode 0 and mode 3 instances)
`timescale 1ns/1ps
module tb_lcd_spi_frame_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        start_a = 1'b0, len8_a = 1'b0, dc_in_a = 1'b0, keep_a = 1'b0;
    logic [15:0] data_in_a = '0;
    logic [7:0]  div_a = '0;
    logic        sck_a, mosi_a, cs_n_a, dc_a, busy_a, done_a;
    logic [15:0] data_out_a;

    logic        start_b = 1'b0, len8_b = 1'b0, dc_in_b = 1'b0, keep_b = 1'b0;
    logic [15:0] data_in_b = '0;
    logic [7:0]  div_b = '0;
    logic        sck_b, mosi_b, cs_n_b, dc_b, busy_b, done_b;
    logic [15:0] data_out_b;

    typedef struct {
        logic [15:0] data;
        int          t_done;
        logic        dc;
        logic        cs;
        logic        len8;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_spi_frame_master #(.DATA_W(16), .DIV_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_in_a), .len8(len8_a),
        .dc_in(dc_in_a), .keep_cs(keep_a), .clk_div(div_a), .miso(mosi_a),
        .sck(sck_a), .mosi(mosi_a), .cs_n(cs_n_a), .dc(dc_a), .busy(busy_a),
        .done(done_a), .data_out(data_out_a)
    );

    lcd_spi_frame_master #(.DATA_W(16), .DIV_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_in_b), .len8(len8_b),
        .dc_in(dc_in_b), .keep_cs(keep_b), .clk_div(div_b), .miso(mosi_b),
        .sck(sck_b), .mosi(mosi_b), .cs_n(cs_n_b), .dc(dc_b), .busy(busy_b),
        .done(done_b), .data_out(data_out_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for instance A: captures MOSI at rising SCK, checks CS/DC during frames, scores done
    logic [15:0] cap_a = '0;
    logic        sck_prev_a = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (sck_a && !sck_prev_a) cap_a = {cap_a[14:0], mosi_a};
            if (busy_a && cs_n_a) chk("a_cs_glitch", cs_n_a, 0);
            if (busy_a && q_a.size() > 0 && dc_a !== q_a[0].dc) chk("a_dc_hold", dc_a, q_a[0].dc);
            if (done_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_done", done_a, 0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    chk("a_data_out", data_out_a, e.data);
                    chk("a_done_cycle", cyc, e.t_done);
                    chk("a_busy_at_done", busy_a, 0);
                    chk("a_cs_at_done", cs_n_a, e.cs);
                    chk("a_mosi_bits", e.len8 ? {8'h00, cap_a[7:0]} : cap_a, e.data);
                end
            end
        end
        sck_prev_a = sck_a;
    end

    // Monitor for instance B: MOSI must not move on rising SCK, scores done
    logic [15:0] cap_b = '0;
    logic        sck_prev_b = 1'b1;
    logic        mosi_prev_b = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (sck_b && !sck_prev_b) begin
                cap_b = {cap_b[14:0], mosi_b};
                chk("b_mosi_stable_rise", mosi_b, mosi_prev_b);
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_done", done_b, 0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("b_data_out", data_out_b, e.data);
                    chk("b_done_cycle", cyc, e.t_done);
                    chk("b_cs_at_done", cs_n_b, e.cs);
                    chk("b_mosi_bits", e.len8 ? {8'h00, cap_b[7:0]} : cap_b, e.data);
                end
            end
        end
        sck_prev_b = sck_b;
        mosi_prev_b = mosi_b;
    end

    // Issue one frame; returns one cycle later (T+1) after checking the accept response
    task automatic send(input bit sel, input logic [15:0] d, input logic l8, input logic dcv,
                        input logic keep, input logic [7:0] div);
        exp_t e;
        int   n;
        n = l8 ? 8 : 16;
        e.data   = l8 ? {8'h00, d[7:0]} : d;
        e.t_done = cyc + (2 * n + 2) * (int'(div) + 1);
        e.dc     = dcv;
        e.cs     = ~keep;
        e.len8   = l8;
        if (!sel) begin
            data_in_a = d; len8_a = l8; dc_in_a = dcv; keep_a = keep; div_a = div; start_a = 1'b1;
            q_a.push_back(e);
        end else begin
            data_in_b = d; len8_b = l8; dc_in_b = dcv; keep_b = keep; div_b = div; start_b = 1'b1;
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        if (!sel) begin
            start_a = 1'b0;
            chk("a_busy_t1", busy_a, 1);
            chk("a_cs_t1", cs_n_a, 0);
            chk("a_dc_t1", dc_a, dcv);
            chk("a_mosi_first", mosi_a, l8 ? d[7] : d[15]);
            data_in_a = ~d; len8_a = ~l8; dc_in_a = ~dcv; div_a = 8'h5A;
        end else begin
            start_b = 1'b0;
            chk("b_busy_t1", busy_b, 1);
            chk("b_cs_t1", cs_n_b, 0);
            chk("b_sck_t1", sck_b, 1);
            data_in_b = ~d; len8_b = ~l8; dc_in_b = ~dcv; div_b = 8'h5A;
        end
    endtask

    // Wait (bounded) until the selected instance pulses done; ends at that negedge
    task automatic wait_done(input bit sel, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            seen = sel ? done_b : done_a;
        end
        if (!seen) chk(sel ? "b_done_timeout" : "a_done_timeout", 0, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_sck", sck_a, 0);
        chk("rst_a_cs", cs_n_a, 1);
        chk("rst_a_mosi", mosi_a, 0);
        chk("rst_a_dc", dc_a, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_a_done", done_a, 0);
        chk("rst_a_data", data_out_a, 0);
        chk("rst_b_sck", sck_b, 1);
        chk("rst_b_cs", cs_n_b, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 8-bit command, fastest divider
        send(0, 16'h00AB, 1, 0, 0, 8'd0);
        wait_done(0, 100);
        @(negedge clk);
        chk("a_cs_idle_after", cs_n_a, 1);

        // 16-bit pixel, divider 3
        @(posedge clk); #1;
        send(0, 16'hF800, 0, 1, 0, 8'd3);
        wait_done(0, 300);

        // Burst: RAMWR with CS held, then pixel issued in the done cycle
        @(posedge clk); #1;
        send(0, 16'h002C, 1, 0, 1, 8'd0);
        wait_done(0, 100);
        chk("a_burst_dc_first", dc_a, 0);
        send(0, 16'h07E0, 0, 1, 0, 8'd0);
        wait_done(0, 100);
        @(negedge clk);
        chk("a_burst_cs_released", cs_n_a, 1);

        // Starts during a frame are ignored
        @(posedge clk); #1;
        send(0, 16'h00AB, 1, 0, 0, 8'd1);
        repeat (3) @(posedge clk);
        #1 data_in_a = 16'h0055; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 data_in_a = 16'h1234; len8_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done(0, 200);
        repeat (40) @(negedge clk);

        // Reset in the middle of a transfer
        @(posedge clk); #1;
        send(0, 16'h00AB, 1, 0, 0, 8'd0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        q_a.delete();
        #1;
        chk("midrst_sck", sck_a, 0);
        chk("midrst_cs", cs_n_a, 1);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_data", data_out_a, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        send(0, 16'h00AB, 1, 0, 0, 8'd0);
        wait_done(0, 100);

        // Mode 3 instance
        @(posedge clk); #1;
        send(1, 16'h001F, 0, 1, 0, 8'd1);
        wait_done(1, 200);
        @(negedge clk);
        chk("b_sck_idle_after", sck_b, 1);

        repeat (10) @(negedge clk);
        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
